// File: rtl/set_demux_pkg.sv
// rtl/set_demux_pkg.sv - shared states, BCD digit limits and digit index constants for set_demux
// Purpose : common types and constants for the time/alarm edit controller.
// Contents: state_t, per-digit BCD limits, digit index constants,
//           next-state and digit-index helper functions.
package set_demux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EDIT_H1 = 3'd1,
        ST_EDIT_H0 = 3'd2,
        ST_EDIT_M1 = 3'd3,
        ST_EDIT_M0 = 3'd4,
        ST_COMMIT  = 3'd5
    } state_t;

    // Highest legal value of each BCD digit before wrapping to 0.
    localparam logic [3:0] LIM_H1    = 4'd2;
    localparam logic [3:0] LIM_H0    = 4'd9;
    localparam logic [3:0] LIM_H0_H2 = 4'd3;   // H0 limit while H1 == 2
    localparam logic [3:0] LIM_M1    = 4'd5;
    localparam logic [3:0] LIM_M0    = 4'd9;

    localparam logic [1:0] DIGIT_H1 = 2'd3;
    localparam logic [1:0] DIGIT_H0 = 2'd2;
    localparam logic [1:0] DIGIT_M1 = 2'd1;
    localparam logic [1:0] DIGIT_M0 = 2'd0;

    // State reached from an edit state when next_pulse is seen.
    function automatic state_t advance_state(input state_t s);
        case (s)
            ST_EDIT_H1: advance_state = ST_EDIT_H0;
            ST_EDIT_H0: advance_state = ST_EDIT_M1;
            ST_EDIT_M1: advance_state = ST_EDIT_M0;
            ST_EDIT_M0: advance_state = ST_COMMIT;
            default:    advance_state = ST_IDLE;
        endcase
    endfunction

    // Digit index presented for a state; IDLE and COMMIT show H1.
    function automatic logic [1:0] digit_of(input state_t s);
        case (s)
            ST_EDIT_H0: digit_of = DIGIT_H0;
            ST_EDIT_M1: digit_of = DIGIT_M1;
            ST_EDIT_M0: digit_of = DIGIT_M0;
            default:    digit_of = DIGIT_H1;
        endcase
    endfunction

endpackage

// File: rtl/set_demux_if.sv
// rtl/set_demux_if.sv - control and data bundle between the edit controller and its user
// Purpose : groups the edit controls, current bank values and write outputs.
// Ports   : master drives sel/set_en/inc_pulse/next_pulse/cur_time/cur_alarm,
//           slave (set_demux) drives wr_data/time_wr_en/alarm_wr_en/digit_idx/editing.
interface set_demux_if;

    logic        sel;
    logic        set_en;
    logic        inc_pulse;
    logic        next_pulse;
    logic [15:0] cur_time;
    logic [15:0] cur_alarm;
    logic [15:0] wr_data;
    logic        time_wr_en;
    logic        alarm_wr_en;
    logic [1:0]  digit_idx;
    logic        editing;

    modport master (
        output sel, set_en, inc_pulse, next_pulse, cur_time, cur_alarm,
        input  wr_data, time_wr_en, alarm_wr_en, digit_idx, editing
    );

    modport slave (
        input  sel, set_en, inc_pulse, next_pulse, cur_time, cur_alarm,
        output wr_data, time_wr_en, alarm_wr_en, digit_idx, editing
    );

endinterface

// File: rtl/set_demux_bcd_digit_inc.sv
// rtl/set_demux_bcd_digit_inc.sv - single BCD digit increment with wrap at a limit
// Purpose : next_value = value + 1, or 0 once value has reached limit.
// Ports   : value (4), limit (4) in; next_value (4) out.
module bcd_digit_inc (
    input  logic [3:0] value,
    input  logic [3:0] limit,
    output logic [3:0] next_value
);

    // ">=" rather than "==" so an out-of-range loaded digit still wraps to 0.
    assign next_value = (value >= limit) ? 4'h0 : value + 4'h1;

endmodule

// File: rtl/set_demux.sv
// rtl/set_demux.sv - time/alarm digit edit controller with one-cycle commit strobes
// Purpose : loads the selected bank into a working register, edits it digit by
//           digit (H1, H0, M1, M0) and writes it back to the bank with a strobe.
// Ports   : clk, rst_n (async, active-low), bus (set_demux_if.slave).
module set_demux (
    input  logic       clk,
    input  logic       rst_n,
    set_demux_if.slave bus
);

    import set_demux_pkg::*;

    state_t      state;
    state_t      adv;
    logic [15:0] work;
    logic [15:0] work_inc;
    logic        bank_q;
    logic        lock;
    logic        time_wr_en;
    logic        alarm_wr_en;
    logic [1:0]  digit_idx;
    logic        editing;
    logic [3:0]  cur_digit;
    logic [3:0]  cur_limit;
    logic [3:0]  inc_digit;

    assign adv = advance_state(state);

    // Select the digit under edit and its wrap limit.
    always_comb begin
        cur_digit = 4'h0;
        cur_limit = LIM_M0;
        case (state)
            ST_EDIT_H1: begin
                cur_digit = work[15:12];
                cur_limit = LIM_H1;
            end
            ST_EDIT_H0: begin
                cur_digit = work[11:8];
                cur_limit = (work[15:12] == LIM_H1) ? LIM_H0_H2 : LIM_H0;
            end
            ST_EDIT_M1: begin
                cur_digit = work[7:4];
                cur_limit = LIM_M1;
            end
            ST_EDIT_M0: begin
                cur_digit = work[3:0];
                cur_limit = LIM_M0;
            end
            default: begin
                cur_digit = 4'h0;
                cur_limit = LIM_M0;
            end
        endcase
    end

    bcd_digit_inc u_digit_inc (
        .value      (cur_digit),
        .limit      (cur_limit),
        .next_value (inc_digit)
    );

    // Working register as it would look after an increment this cycle.
    always_comb begin
        work_inc = work;
        case (state)
            ST_EDIT_H1: begin
                work_inc[15:12] = inc_digit;
                // Entering the 20s hours: hours above 23 are not representable.
                if (inc_digit == LIM_H1 && work[11:8] > LIM_H0_H2)
                    work_inc[11:8] = 4'h0;
            end
            ST_EDIT_H0: work_inc[11:8] = inc_digit;
            ST_EDIT_M1: work_inc[7:4]  = inc_digit;
            ST_EDIT_M0: work_inc[3:0]  = inc_digit;
            default:    work_inc = work;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            work        <= 16'h0000;
            bank_q      <= 1'b0;
            lock        <= 1'b0;
            time_wr_en  <= 1'b0;
            alarm_wr_en <= 1'b0;
            digit_idx   <= DIGIT_H1;
            editing     <= 1'b0;
        end else begin
            time_wr_en  <= 1'b0;
            alarm_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // lock blocks re-entry until set_en has been seen low.
                    if (!bus.set_en) begin
                        lock <= 1'b0;
                    end else if (!lock) begin
                        state     <= ST_EDIT_H1;
                        bank_q    <= bus.sel;
                        work      <= bus.sel ? bus.cur_alarm : bus.cur_time;
                        editing   <= 1'b1;
                        digit_idx <= DIGIT_H1;
                    end
                end
                ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0: begin
                    if (!bus.set_en) begin
                        state     <= ST_IDLE;
                        editing   <= 1'b0;
                        digit_idx <= DIGIT_H1;
                    end else begin
                        if (bus.inc_pulse)
                            work <= work_inc;
                        if (bus.next_pulse) begin
                            state     <= adv;
                            digit_idx <= digit_of(adv);
                            if (adv == ST_COMMIT) begin
                                editing     <= 1'b0;
                                time_wr_en  <= ~bank_q;
                                alarm_wr_en <= bank_q;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    // A low set_en during the commit cycle already satisfies re-entry.
                    lock  <= bus.set_en;
                end
                default: begin
                    state     <= ST_IDLE;
                    editing   <= 1'b0;
                    digit_idx <= DIGIT_H1;
                end
            endcase
        end
    end

    assign bus.wr_data     = work;
    assign bus.time_wr_en  = time_wr_en;
    assign bus.alarm_wr_en = alarm_wr_en;
    assign bus.digit_idx   = digit_idx;
    assign bus.editing     = editing;

endmodule

// File: tb/tb_set_demux.sv
// tb/tb_set_demux.sv - directed self-checking bench for set_demux
module tb_set_demux;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    set_demux_if b ();

    set_demux dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {wr_data, time_wr_en, alarm_wr_en, digit_idx, editing}
    wire [20:0] obs = {b.wr_data, b.time_wr_en, b.alarm_wr_en, b.digit_idx, b.editing};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b.sel = 1'b0; b.set_en = 1'b0; b.inc_pulse = 1'b0; b.next_pulse = 1'b0;
        b.cur_time = 16'h4321; b.cur_alarm = 16'h8765;
        step(); step();
        checks++;
        if (obs !== {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL reset_state got %h exp %h", obs, {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL reset_release got %h exp %h", obs, {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0});
        end
    endtask

    task automatic test_time_commit();
        b.sel = 1'b0; b.cur_time = 16'h1259; b.cur_alarm = 16'h0000;
        b.set_en = 1'b1;
        step();
        checks++;
        if (obs !== {16'h1259, 1'b0, 1'b0, 2'd3, 1'b1}) begin
            errors++; $display("FAIL time_entry got %h exp %h", obs, {16'h1259, 1'b0, 1'b0, 2'd3, 1'b1});
        end
        b.next_pulse = 1'b1;
        step();
        checks++;
        if (obs !== {16'h1259, 1'b0, 1'b0, 2'd2, 1'b1}) begin
            errors++; $display("FAIL time_next1 got %h exp %h", obs, {16'h1259, 1'b0, 1'b0, 2'd2, 1'b1});
        end
        step(); step(); step();
        b.next_pulse = 1'b0;
        checks++;
        if (obs !== {16'h1259, 1'b1, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL time_strobe got %h exp %h", obs, {16'h1259, 1'b1, 1'b0, 2'd3, 1'b0});
        end
        // set_en still held: strobe ends and no re-entry happens.
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== {16'h1259, 1'b0, 1'b0, 2'd3, 1'b0}) begin
                errors++; $display("FAIL time_locked_%0d got %h exp %h", i, obs, {16'h1259, 1'b0, 1'b0, 2'd3, 1'b0});
            end
        end
        b.set_en = 1'b0;
        step();
    endtask

    task automatic test_alarm_commit();
        b.sel = 1'b1; b.cur_alarm = 16'h0730; b.cur_time = 16'h1111;
        b.set_en = 1'b1;
        step();
        b.sel = 1'b0;   // must not retarget the edit
        b.next_pulse = 1'b1;
        step(); step();
        b.next_pulse = 1'b0;
        checks++;
        if (obs !== {16'h0730, 1'b0, 1'b0, 2'd1, 1'b1}) begin
            errors++; $display("FAIL alarm_at_m1 got %h exp %h", obs, {16'h0730, 1'b0, 1'b0, 2'd1, 1'b1});
        end
        b.inc_pulse = 1'b1;
        step();
        b.inc_pulse = 1'b0;
        checks++;
        if (obs !== {16'h0740, 1'b0, 1'b0, 2'd1, 1'b1}) begin
            errors++; $display("FAIL alarm_inc_m1 got %h exp %h", obs, {16'h0740, 1'b0, 1'b0, 2'd1, 1'b1});
        end
        b.next_pulse = 1'b1;
        step(); step();
        b.next_pulse = 1'b0;
        checks++;
        if (obs !== {16'h0740, 1'b0, 1'b1, 2'd3, 1'b0}) begin
            errors++; $display("FAIL alarm_strobe got %h exp %h", obs, {16'h0740, 1'b0, 1'b1, 2'd3, 1'b0});
        end
        b.set_en = 1'b0;
        step();
        checks++;
        if (obs !== {16'h0740, 1'b0, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL alarm_after got %h exp %h", obs, {16'h0740, 1'b0, 1'b0, 2'd3, 1'b0});
        end
    endtask

    task automatic test_h1_clamp();
        b.sel = 1'b0; b.cur_time = 16'h1800;
        b.set_en = 1'b1;
        step();
        b.inc_pulse = 1'b1;
        step();
        checks++;
        if (obs !== {16'h2000, 1'b0, 1'b0, 2'd3, 1'b1}) begin
            errors++; $display("FAIL h1_clamp got %h exp %h", obs, {16'h2000, 1'b0, 1'b0, 2'd3, 1'b1});
        end
        step();
        b.inc_pulse = 1'b0;
        checks++;
        if (obs !== {16'h0000, 1'b0, 1'b0, 2'd3, 1'b1}) begin
            errors++; $display("FAIL h1_wrap got %h exp %h", obs, {16'h0000, 1'b0, 1'b0, 2'd3, 1'b1});
        end
        b.set_en = 1'b0;
        step();
    endtask

    task automatic test_digit_wraps();
        b.sel = 1'b0; b.cur_time = 16'h2359;
        b.set_en = 1'b1;
        step();
        b.next_pulse = 1'b1;
        step();
        b.next_pulse = 1'b0;
        b.inc_pulse = 1'b1;
        step();
        b.inc_pulse = 1'b0;
        checks++;
        if (obs !== {16'h2059, 1'b0, 1'b0, 2'd2, 1'b1}) begin
            errors++; $display("FAIL h0_wrap_at3 got %h exp %h", obs, {16'h2059, 1'b0, 1'b0, 2'd2, 1'b1});
        end
        b.next_pulse = 1'b1;
        step();
        // inc and next together: M1 wraps and state advances to M0 on one edge.
        b.inc_pulse = 1'b1;
        step();
        b.inc_pulse = 1'b0;
        b.next_pulse = 1'b0;
        checks++;
        if (obs !== {16'h2009, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL m1_wrap_adv got %h exp %h", obs, {16'h2009, 1'b0, 1'b0, 2'd0, 1'b1});
        end
        b.inc_pulse = 1'b1;
        step();
        b.inc_pulse = 1'b0;
        checks++;
        if (obs !== {16'h2000, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL m0_wrap got %h exp %h", obs, {16'h2000, 1'b0, 1'b0, 2'd0, 1'b1});
        end
        b.next_pulse = 1'b1;
        step();
        b.next_pulse = 1'b0;
        checks++;
        if (obs !== {16'h2000, 1'b1, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL wraps_strobe got %h exp %h", obs, {16'h2000, 1'b1, 1'b0, 2'd3, 1'b0});
        end
        b.set_en = 1'b0;
        step();
    endtask

    task automatic test_abort();
        b.sel = 1'b0; b.cur_time = 16'h1234;
        b.set_en = 1'b1;
        step();
        b.next_pulse = 1'b1;
        step(); step();
        b.next_pulse = 1'b0;
        checks++;
        if (obs !== {16'h1234, 1'b0, 1'b0, 2'd1, 1'b1}) begin
            errors++; $display("FAIL abort_at_m1 got %h exp %h", obs, {16'h1234, 1'b0, 1'b0, 2'd1, 1'b1});
        end
        b.set_en = 1'b0;
        step();
        checks++;
        if (obs !== {16'h1234, 1'b0, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL abort_idle got %h exp %h", obs, {16'h1234, 1'b0, 1'b0, 2'd3, 1'b0});
        end
        // Pulses in IDLE are ignored.
        b.inc_pulse = 1'b1; b.next_pulse = 1'b1;
        step(); step();
        b.inc_pulse = 1'b0; b.next_pulse = 1'b0;
        checks++;
        if (obs !== {16'h1234, 1'b0, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL idle_ignore got %h exp %h", obs, {16'h1234, 1'b0, 1'b0, 2'd3, 1'b0});
        end
    endtask

    task automatic test_reset_mid_edit();
        b.sel = 1'b0; b.cur_time = 16'h0930;
        b.set_en = 1'b1;
        step();
        b.next_pulse = 1'b1;
        step(); step(); step();
        checks++;
        if (obs !== {16'h0930, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL rst_at_m0 got %h exp %h", obs, {16'h0930, 1'b0, 1'b0, 2'd0, 1'b1});
        end
        // next_pulse still pending; reset lands before the committing edge.
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL rst_async got %h exp %h", obs, {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0});
        end
        step();
        checks++;
        if (obs !== {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL rst_no_strobe got %h exp %h", obs, {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0});
        end
        b.next_pulse = 1'b0;
        b.set_en = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0}) begin
            errors++; $display("FAIL rst_after got %h exp %h", obs, {16'h0000, 1'b0, 1'b0, 2'd3, 1'b0});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_time_commit();
        test_alarm_commit();
        test_h1_clamp();
        test_digit_wraps();
        test_abort();
        test_reset_mid_edit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/set_demux.md
SET_DEMUX -- requirements
Module: set_demux

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: sel  input  1  target bank (0 = time, 1 = alarm); sampled only on edit entry.
REQ-004 SHALL have port: set_en  input  1  level; high requests and holds edit mode.
REQ-005 SHALL have port: inc_pulse  input  1  one-cycle pulse; increment current digit.
REQ-006 SHALL have port: next_pulse  input  1  one-cycle pulse; advance to next digit or commit.
REQ-007 SHALL have port: cur_time  input  16  current time, 4 BCD digits {H1,H0,M1,M0}.
REQ-008 SHALL have port: cur_alarm  input  16  current alarm, same format.
REQ-009 SHALL have port: wr_data  output  16  edited value, 4 BCD digits.
REQ-010 SHALL have port: time_wr_en  output  1  one-cycle write strobe to the time bank.
REQ-011 SHALL have port: alarm_wr_en  output  1  one-cycle write strobe to the alarm bank.
REQ-012 SHALL have port: digit_idx  output  2  digit being edited (3 = H1, 2 = H0, 1 = M1, 0 = M0).
REQ-013 SHALL have port: editing  output  1  high in any EDIT state.

Function
REQ-014 SHALL implement states IDLE, EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0, COMMIT.
REQ-015 IDLE with set_en=1 SHALL go to EDIT_H1; same edge latches sel into bank_q and loads the working register from cur_time (sel=0) or cur_alarm (sel=1).
REQ-016 In EDIT states, next_pulse SHALL advance H1 -> H0 -> M1 -> M0 -> COMMIT.
REQ-017 COMMIT SHALL last exactly one cycle; it asserts time_wr_en if bank_q=0 or alarm_wr_en if bank_q=1, never both; then returns to IDLE.
REQ-018 wr_data SHALL always equal the working register; it is valid and stable during the strobe cycle.
REQ-019 inc_pulse SHALL increment the current digit with wrap to 0 at these limits: H1 max 2; H0 max 9, or 3 when H1=2; M1 max 5; M0 max 9.
REQ-020 When H1 becomes 2 while H0>3, H0 SHALL be cleared to 0 on the same edge.
REQ-021 inc_pulse and next_pulse in the same cycle SHALL store the incremented digit and advance the state on that edge.
REQ-022 set_en low in any EDIT state SHALL abort to IDLE on the next edge with no write strobe; the working register is kept.
REQ-023 set_en still high on return to IDLE SHALL NOT start a new edit; re-entry requires set_en low for at least one cycle.
REQ-024 inc_pulse and next_pulse SHALL be ignored in IDLE and COMMIT.
REQ-025 Changes on sel during an edit SHALL have no effect.
REQ-026 digit_idx SHALL be 3 in IDLE and COMMIT.

Reset
REQ-027 rst_n low SHALL force state IDLE, working register 16'h0000, bank_q 0, re-entry lock cleared, and outputs to: wr_data 0, time_wr_en 0, alarm_wr_en 0, digit_idx 3, editing 0.
REQ-028 Reset asserted mid-edit or during COMMIT SHALL suppress any pending write strobe.

Structure
REQ-029 State encoding, BCD digit limits (2, 9, 3, 5, 9) and digit index constants SHALL live in the shared clock package.
REQ-030 Per-digit increment/wrap logic SHALL be one sub-module, bcd_digit_inc (inputs: value, limit; output: next value).

Verification
REQ-031 Bench SHALL cover: sel=0, cur_time=16'h1259, set_en high, next x4 -> one-cycle time_wr_en, wr_data=16'h1259, alarm_wr_en stays 0.
REQ-032 Bench SHALL cover: sel=1, cur_alarm=16'h0730, inc on M1 once, commit -> alarm_wr_en pulse, wr_data=16'h0740.
REQ-033 Bench SHALL cover: cur_time=16'h1800, inc H1 once -> H1=2, H0=0 (clamp); inc H1 again -> H1=0.
REQ-034 Bench SHALL cover: M0=9, inc -> M0=0; M1=5, inc -> M1=0; H1=2, H0=3, inc H0 -> H0=0.
REQ-035 Bench SHALL cover: set_en dropped in EDIT_M1 -> IDLE next cycle, no strobe; set_en held high after commit -> stays IDLE.
REQ-036 Bench SHALL cover: rst_n low in EDIT_M0 with next_pulse pending -> no strobe, all outputs at reset values.
